// File: rtl/lcd_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// lcd_sequencer_pkg
// Shared definitions for the HD44780-style 4-bit LCD write sequencer:
//   - FSM state encoding
//   - default timing constants (clocks at 50 MHz)
//   - power-up init command table (single nibbles, then full bytes)
//   - small helpers used by the top level
// -----------------------------------------------------------------------------
package lcd_sequencer_pkg;

  // Default timing, in clocks of a 50 MHz system clock.
  localparam int DEF_SETUP   = 3;       // nibble/RS valid to E rise (>= 40 ns)
  localparam int DEF_EHIGH   = 12;      // E high width
  localparam int DEF_GAP     = 50;      // upper-nibble E fall to lower-nibble drive
  localparam int DEF_WAIT    = 2000;    // post-byte wait, 40 us
  localparam int DEF_CLRWAIT = 82000;   // post-byte wait for clear/home, 1.64 ms
  localparam int DEF_PWRWAIT = 750000;  // power-up settle, 15 ms
  localparam int DEF_INITW1  = 205000;  // after first 0x3 nibble, 4.1 ms
  localparam int DEF_INITW2  = 5000;    // after second 0x3 nibble, 100 us

  // Init table sizes: four single nibbles followed by four full bytes.
  localparam int INIT_NIBBLES = 4;
  localparam int INIT_BYTES   = 4;

  typedef enum logic [3:0] {
    PWR_WAIT,
    INIT_NIB,
    INIT_WAIT,
    IDLE,
    SETUP_HI,
    PULSE_HI,
    GAP,
    SETUP_LO,
    PULSE_LO,
    BYTE_WAIT
  } lcd_state_e;

  // Which wait follows each init nibble.
  typedef enum logic [1:0] {
    WAIT_INIT1,
    WAIT_INIT2,
    WAIT_BYTE
  } init_wait_e;

  // Single-nibble init sequence: 0x3, 0x3, 0x3, 0x2 (switch to 4-bit mode).
  function automatic logic [3:0] init_nibble(input logic [1:0] idx);
    case (idx)
      2'd3:    return 4'h2;
      default: return 4'h3;
    endcase
  endfunction

  function automatic init_wait_e init_wait_sel(input logic [1:0] idx);
    case (idx)
      2'd0:    return WAIT_INIT1;
      2'd1:    return WAIT_INIT2;
      default: return WAIT_BYTE;
    endcase
  endfunction

  // Full-byte init commands: function set, entry mode, display on, clear.
  function automatic logic [7:0] init_byte(input logic [1:0] idx);
    case (idx)
      2'd0:    return 8'h28;
      2'd1:    return 8'h06;
      2'd2:    return 8'h0C;
      default: return 8'h01;
    endcase
  endfunction

  // Clear display (0x01) and return home (0x02) need the long wait.
  function automatic logic is_slow_cmd(input logic rs, input logic [7:0] data);
    return !rs && ((data == 8'h01) || (data == 8'h02));
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lcd_timer.sv
// -----------------------------------------------------------------------------
// lcd_timer
// Loadable down-counter with a zero flag. The counter stops at zero until it
// is reloaded.
//   clk        : system clock
//   rst_n      : asynchronous active-low reset (count <= RST_VAL)
//   load_i     : load load_val_i on this edge (has priority over counting)
//   load_val_i : value to load
//   count_o    : current count
//   done_o     : count is zero
// -----------------------------------------------------------------------------
module lcd_timer #(
  parameter int           W       = 20,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic [W-1:0] count_o,
  output logic         done_o
);

  logic [W-1:0] count_q;

  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= RST_VAL;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (count_q != '0) begin
      count_q <= count_q - W'(1);
    end
  end

  assign count_o = count_q;
  assign done_o  = (count_q == '0);

endmodule

// File: rtl/lcd_sequencer.sv
// -----------------------------------------------------------------------------
// lcd_sequencer
// Write-only 4-bit LCD interface. After reset it waits for panel power-up,
// runs the standard nibble/byte init sequence, then accepts bytes one at a
// time and emits each as two E-strobed nibbles (upper first) followed by a
// command-dependent settle wait. The panel is never polled.
//   Clock      : system clock, all state on its rising edge
//   Reset      : asynchronous active-low reset, restarts the init sequence
//   iData      : byte to write, sampled on acceptance
//   iRS        : register select (0 command, 1 data), sampled on acceptance
//   iValid     : write request; accepted on an edge where oReady is high
//   oReady     : sequencer idle and able to accept a byte
//   oInitDone  : power-up init sequence complete (sticky until reset)
//   oLCD_E     : panel enable strobe
//   oLCD_RS    : panel register select
//   oLCD_RW    : panel read/write, always 0 (write)
//   oLCD_Data  : panel data nibble D7..D4
// -----------------------------------------------------------------------------
module lcd_sequencer
  import lcd_sequencer_pkg::*;
#(
  parameter int P_SETUP   = DEF_SETUP,
  parameter int P_EHIGH   = DEF_EHIGH,
  parameter int P_GAP     = DEF_GAP,
  parameter int P_WAIT    = DEF_WAIT,
  parameter int P_CLRWAIT = DEF_CLRWAIT,
  parameter int P_PWRWAIT = DEF_PWRWAIT,
  parameter int P_INITW1  = DEF_INITW1,
  parameter int P_INITW2  = DEF_INITW2
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [7:0] iData,
  input  logic       iRS,
  input  logic       iValid,
  output logic       oReady,
  output logic       oInitDone,
  output logic       oLCD_E,
  output logic       oLCD_RS,
  output logic       oLCD_RW,
  output logic [3:0] oLCD_Data
);

  // Timer must hold the largest value ever loaded, including the combined
  // setup+pulse window used for single init nibbles.
  localparam int P_MAX = max_int(max_int(max_int(P_PWRWAIT, P_INITW1),
                                         max_int(P_INITW2, P_CLRWAIT)),
                                 max_int(max_int(P_WAIT, P_GAP),
                                         P_SETUP + P_EHIGH));
  localparam int TW = $clog2(P_MAX + 1);

  // A state lasting N clocks is entered with N-1 loaded: the exit edge is the
  // one that sees the counter at zero.
  localparam logic [TW-1:0] T_SETUP   = TW'(P_SETUP - 1);
  localparam logic [TW-1:0] T_EHIGH   = TW'(P_EHIGH - 1);
  localparam logic [TW-1:0] T_GAP     = TW'(P_GAP - 1);
  localparam logic [TW-1:0] T_WAIT    = TW'(P_WAIT - 1);
  localparam logic [TW-1:0] T_CLRWAIT = TW'(P_CLRWAIT - 1);
  localparam logic [TW-1:0] T_INITW1  = TW'(P_INITW1 - 1);
  localparam logic [TW-1:0] T_INITW2  = TW'(P_INITW2 - 1);
  localparam logic [TW-1:0] T_NIB     = TW'(P_SETUP + P_EHIGH - 1);
  // Count seen on the edge that ends the setup part of an init nibble.
  localparam logic [TW-1:0] T_NIB_RISE = TW'(P_EHIGH);

  // Init step: 0..3 single nibbles, 4..7 full bytes.
  localparam logic [2:0] LAST_NIB_STEP = 3'(INIT_NIBBLES - 1);
  localparam logic [2:0] LAST_STEP     = 3'(INIT_NIBBLES + INIT_BYTES - 1);

  lcd_state_e   state_q;
  logic [2:0]   step_q;
  logic [7:0]   byte_q;
  logic         rs_q;
  logic         ready_q;
  logic         init_done_q;
  logic         lcd_e_q;
  logic         lcd_rs_q;
  logic [3:0]   lcd_data_q;

  logic          timer_load;
  logic [TW-1:0] timer_val;
  logic [TW-1:0] timer_count;
  logic          timer_done;
  logic          accept;
  logic [7:0]    init_cmd;
  logic          init_last;

  function automatic logic [TW-1:0] init_wait_val(input logic [1:0] idx);
    case (init_wait_sel(idx))
      WAIT_INIT1: return T_INITW1;
      WAIT_INIT2: return T_INITW2;
      default:    return T_WAIT;
    endcase
  endfunction

  // ready_q is only ever high in IDLE, so this is the whole handshake.
  assign accept    = iValid & ready_q;
  // Next init byte to send: step 3 -> table entry 0, step 4 -> 1, ...
  assign init_cmd  = init_byte(2'(step_q - LAST_NIB_STEP));
  assign init_last = init_done_q || (step_q == LAST_STEP);

  // Timer reload: loads the duration of the state being entered, on the same
  // edge the FSM below moves into it.
  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case can leave a value held (which would be a latch).
  always_comb begin
    timer_load = 1'b0;
    timer_val  = '0;
    case (state_q)
      PWR_WAIT: begin
        timer_load = timer_done;
        timer_val  = T_NIB;
      end
      INIT_NIB: begin
        timer_load = timer_done;
        timer_val  = init_wait_val(step_q[1:0]);
      end
      INIT_WAIT: begin
        timer_load = timer_done;
        timer_val  = (step_q == LAST_NIB_STEP) ? T_SETUP : T_NIB;
      end
      IDLE: begin
        timer_load = accept;
        timer_val  = T_SETUP;
      end
      SETUP_HI, SETUP_LO: begin
        timer_load = timer_done;
        timer_val  = T_EHIGH;
      end
      PULSE_HI: begin
        timer_load = timer_done;
        timer_val  = T_GAP;
      end
      GAP: begin
        timer_load = timer_done;
        timer_val  = T_SETUP;
      end
      PULSE_LO: begin
        timer_load = timer_done;
        timer_val  = is_slow_cmd(rs_q, byte_q) ? T_CLRWAIT : T_WAIT;
      end
      BYTE_WAIT: begin
        // Going to IDLE needs no load; the counter rests at zero.
        timer_load = timer_done && !init_last;
        timer_val  = T_SETUP;
      end
      default: begin
        timer_load = 1'b0;
        timer_val  = '0;
      end
    endcase
  end

  lcd_timer #(
    .W       (TW),
    .RST_VAL (TW'(P_PWRWAIT))
  ) u_timer (
    .clk        (Clock),
    .rst_n      (Reset),
    .load_i     (timer_load),
    .load_val_i (timer_val),
    .count_o    (timer_count),
    .done_o     (timer_done)
  );

  // Sequencer FSM with all panel outputs registered.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q     <= PWR_WAIT;
      step_q      <= '0;
      byte_q      <= '0;
      rs_q        <= 1'b0;
      ready_q     <= 1'b0;
      init_done_q <= 1'b0;
      lcd_e_q     <= 1'b0;
      lcd_rs_q    <= 1'b0;
      lcd_data_q  <= '0;
    end else begin
      case (state_q)
        PWR_WAIT: begin
          if (timer_done) begin
            state_q    <= INIT_NIB;
            step_q     <= '0;
            lcd_rs_q   <= 1'b0;
            lcd_data_q <= init_nibble(2'd0);
          end
        end
        // One state covers setup and pulse of a lone init nibble: E rises
        // once P_SETUP clocks have elapsed and falls on exit.
        INIT_NIB: begin
          if (timer_done) begin
            state_q <= INIT_WAIT;
            lcd_e_q <= 1'b0;
          end else if (timer_count == T_NIB_RISE) begin
            lcd_e_q <= 1'b1;
          end
        end
        INIT_WAIT: begin
          if (timer_done) begin
            step_q <= step_q + 3'd1;
            if (step_q == LAST_NIB_STEP) begin
              state_q    <= SETUP_HI;
              byte_q     <= init_cmd;
              rs_q       <= 1'b0;
              lcd_data_q <= init_cmd[7:4];
            end else begin
              state_q    <= INIT_NIB;
              lcd_data_q <= init_nibble(2'(step_q + 3'd1));
            end
          end
        end
        IDLE: begin
          if (accept) begin
            state_q    <= SETUP_HI;
            ready_q    <= 1'b0;
            byte_q     <= iData;
            rs_q       <= iRS;
            lcd_rs_q   <= iRS;
            lcd_data_q <= iData[7:4];
          end
        end
        SETUP_HI: begin
          if (timer_done) begin
            state_q <= PULSE_HI;
            lcd_e_q <= 1'b1;
          end
        end
        PULSE_HI: begin
          if (timer_done) begin
            state_q <= GAP;
            lcd_e_q <= 1'b0;
          end
        end
        GAP: begin
          if (timer_done) begin
            state_q    <= SETUP_LO;
            lcd_data_q <= byte_q[3:0];
          end
        end
        SETUP_LO: begin
          if (timer_done) begin
            state_q <= PULSE_LO;
            lcd_e_q <= 1'b1;
          end
        end
        PULSE_LO: begin
          if (timer_done) begin
            state_q <= BYTE_WAIT;
            lcd_e_q <= 1'b0;
          end
        end
        BYTE_WAIT: begin
          if (timer_done) begin
            if (init_last) begin
              state_q     <= IDLE;
              ready_q     <= 1'b1;
              init_done_q <= 1'b1;
            end else begin
              state_q    <= SETUP_HI;
              step_q     <= step_q + 3'd1;
              byte_q     <= init_cmd;
              lcd_data_q <= init_cmd[7:4];
            end
          end
        end
        default: begin
          state_q <= PWR_WAIT;
          lcd_e_q <= 1'b0;
        end
      endcase
    end
  end

  assign oReady    = ready_q;
  assign oInitDone = init_done_q;
  assign oLCD_E    = lcd_e_q;
  assign oLCD_RS   = lcd_rs_q;
  assign oLCD_RW   = 1'b0;
  assign oLCD_Data = lcd_data_q;

endmodule

// File: tb/tb_lcd_sequencer.sv
// -----------------------------------------------------------------------------
// tb_lcd_sequencer
// Self-checking bench for lcd_sequencer with short timing parameters.
// A negedge model tracks expected E-fall nibbles, the per-cycle pin waveform
// of every accepted byte, and the oReady/oInitDone timing; the main process
// drives directed stimulus and pins a few hand-computed values.
// -----------------------------------------------------------------------------
module tb_lcd_sequencer;

  localparam int S   = 2;
  localparam int H   = 4;
  localparam int G   = 3;
  localparam int W   = 10;
  localparam int CLR = 40;
  localparam int PWR = 20;
  localparam int I1  = 30;
  localparam int I2  = 15;
  localparam int INF = 32'h7fff_ffff;

  logic       Clock = 1'b0;
  logic       Reset;
  logic [7:0] iData;
  logic       iRS;
  logic       iValid;
  logic       oReady;
  logic       oInitDone;
  logic       oLCD_E;
  logic       oLCD_RS;
  logic       oLCD_RW;
  logic [3:0] oLCD_Data;

  lcd_sequencer #(
    .P_SETUP   (S),
    .P_EHIGH   (H),
    .P_GAP     (G),
    .P_WAIT    (W),
    .P_CLRWAIT (CLR),
    .P_PWRWAIT (PWR),
    .P_INITW1  (I1),
    .P_INITW2  (I2)
  ) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .iData     (iData),
    .iRS       (iRS),
    .iValid    (iValid),
    .oReady    (oReady),
    .oInitDone (oInitDone),
    .oLCD_E    (oLCD_E),
    .oLCD_RS   (oLCD_RS),
    .oLCD_RW   (oLCD_RW),
    .oLCD_Data (oLCD_Data)
  );

  always #5 Clock = ~Clock;

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // ---------------------------------------------------------------- model
  logic [3:0] init_seq [0:11] = '{4'h3, 4'h3, 4'h3, 4'h2, 4'h2, 4'h8,
                                  4'h0, 4'h6, 4'h0, 4'hC, 4'h0, 4'h1};

  int         cyc = 0;
  int         ready_due;
  int         init_due;
  bit         have_byte;
  int         byte_start;
  logic [7:0] cur_byte;
  logic       cur_rs;
  logic [4:0] exp_q [$];
  bit         e_prev;
  int         e_width;
  logic [4:0] e_cap;
  int         fall_cnt;
  int         acc_cnt = 0;

  always @(posedge Clock) cyc <= cyc + 1;

  function automatic void model_reset();
    ready_due = INF;
    init_due  = INF;
    have_byte = 1'b0;
    e_prev    = 1'b0;
    e_width   = 0;
    fall_cnt  = 0;
    exp_q.delete();
    for (int i = 0; i < 12; i++) exp_q.push_back({1'b0, init_seq[i]});
  endfunction

  initial begin
    int         m;
    int         d;
    bit         exp_rdy;
    bit         exp_e;
    logic [3:0] exp_nib;
    logic [4:0] pins;
    model_reset();
    forever begin
      @(negedge Clock);
      if (!Reset) begin
        check("reset_pins", {oLCD_E, oLCD_RS, oLCD_RW, oLCD_Data, oReady, oInitDone}, '0);
        model_reset();
      end else begin
        m       = cyc;
        exp_rdy = (m >= ready_due);
        check("ready", oReady, exp_rdy);
        check("init_done", oInitDone, m >= init_due);
        check("rw_low", oLCD_RW, 1'b0);
        // Waveform of the most recently accepted byte, by offset from acceptance.
        if (have_byte) begin
          d       = m - byte_start;
          exp_e   = (d >= S && d < S + H) || (d >= 2*S + H + G && d < 2*S + 2*H + G);
          exp_nib = (d < S + H + G) ? cur_byte[7:4] : cur_byte[3:0];
          check("wave_e", oLCD_E, exp_e);
          check("wave_data", oLCD_Data, exp_nib);
          check("wave_rs", oLCD_RS, cur_rs);
        end
        // Every E pulse: width, stability while high, and nibble order.
        pins = {oLCD_RS, oLCD_Data};
        if (oLCD_E && !e_prev) begin
          e_cap   = pins;
          e_width = 1;
        end else if (oLCD_E) begin
          e_width++;
          check("hold_e_high", pins, e_cap);
        end else if (e_prev) begin
          check("e_width", e_width, H);
          check("pulse_expected", exp_q.size() != 0, 1'b1);
          if (exp_q.size() != 0) check("nibble_order", e_cap, exp_q.pop_front());
          fall_cnt++;
          if (fall_cnt == 12 && init_due == INF) begin
            init_due  = m + CLR;   // last init byte is 0x01: long wait
            ready_due = m + CLR;
          end
        end
        e_prev = oLCD_E;
        // Acceptance happens on the coming edge.
        if (iValid && exp_rdy) begin
          exp_q.push_back({iRS, iData[7:4]});
          exp_q.push_back({iRS, iData[3:0]});
          have_byte  = 1'b1;
          byte_start = m + 1;
          cur_byte   = iData;
          cur_rs     = iRS;
          ready_due  = m + 1 + 2*S + 2*H + G +
                       ((!iRS && (iData == 8'h01 || iData == 8'h02)) ? CLR : W);
          acc_cnt++;
        end
      end
    end
  end

  // ---------------------------------------------------------------- tasks
  task automatic wait_ready();
    int n = 0;
    while (!oReady && n < 2000) begin
      @(posedge Clock); #1;
      n++;
    end
    check("ready_wait", oReady, 1'b1);
  endtask

  task automatic wait_init();
    int n = 0;
    while (!oInitDone && n < 5000) begin
      @(posedge Clock); #1;
      n++;
    end
    check("init_wait", oInitDone, 1'b1);
  endtask

  task automatic send(input logic rs, input logic [7:0] data, input int exp_lat, input string name);
    int lat = 0;
    wait_ready();
    iRS = rs; iData = data; iValid = 1'b1;
    @(posedge Clock); #1;
    iValid = 1'b0;
    check({name, "_busy"}, oReady, 1'b0);
    while (!oReady && lat < 500) begin
      @(posedge Clock); #1;
      lat++;
    end
    check({name, "_latency"}, lat, exp_lat);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time %0t reached limit 1000000", $time);
    $fatal(1);
  end

  // ---------------------------------------------------------------- stimulus
  initial begin
    int f0;
    int a0;
    Reset = 1'b0; iValid = 1'b0; iData = '0; iRS = 1'b0;
    repeat (3) @(posedge Clock);
    #1;
    check("por_outputs", {oLCD_E, oLCD_RS, oLCD_RW, oLCD_Data, oReady, oInitDone}, '0);
    Reset = 1'b1;

    // Full init: 12 nibbles 3,3,3,2,2,8,0,6,0,C,0,1 then ready.
    wait_init();
    check("init_ready", oReady, 1'b1);
    check("init_pulses", fall_cnt, 12);
    check("init_queue_drained", exp_q.size(), 0);

    // Data byte and command latencies.
    send(1'b1, 8'h41, 25, "data_41");
    send(1'b0, 8'h01, 55, "cmd_clear");
    send(1'b0, 8'h80, 25, "cmd_ddram");
    send(1'b0, 8'h02, 55, "cmd_home");

    // iValid held with changing iData: only bytes at ready edges are taken.
    wait_ready();
    a0 = acc_cnt; f0 = fall_cnt;
    iRS = 1'b1; iValid = 1'b1;
    for (int i = 0; i < 60; i++) begin
      iData = 8'h30 + 8'(i);
      @(posedge Clock); #1;
    end
    iValid = 1'b0;
    wait_ready();
    check("stream_accepts", acc_cnt - a0, 3);
    check("stream_pulses", fall_cnt - f0, 6);

    // 16 back-to-back data bytes.
    f0 = fall_cnt;
    for (int i = 0; i < 16; i++) send(1'b1, 8'hA0 + 8'(i * 7), 25, "b2b");
    check("b2b_pulses", fall_cnt - f0, 32);
    check("b2b_queue_drained", exp_q.size(), 0);

    // Reset while E is high in the lower nibble.
    wait_ready();
    iRS = 1'b1; iData = 8'hA5; iValid = 1'b1;
    @(posedge Clock); #1;
    iValid = 1'b0;
    repeat (12) @(posedge Clock);
    #1;
    check("pre_reset_e", oLCD_E, 1'b1);
    Reset = 1'b0;
    #1;
    check("reset_e_now", oLCD_E, 1'b0);
    check("reset_pins_now", {oLCD_E, oLCD_RS, oLCD_RW, oLCD_Data, oReady, oInitDone}, '0);
    repeat (3) @(posedge Clock);
    #1;
    Reset = 1'b1;
    wait_init();
    check("reinit_pulses", fall_cnt, 12);
    check("reinit_ready", oReady, 1'b1);
    send(1'b1, 8'h41, 25, "post_reset");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
